// File: rtl/db_pkg.sv
// Shared constants and types for the SRIO doorbell responder.
package db_pkg;

  localparam logic [3:0] FTYPE_NREAD  = 4'h2;
  localparam logic [3:0] FTYPE_NWRITE = 4'h5;
  localparam logic [3:0] FTYPE_SWRITE = 4'h6;
  localparam logic [3:0] FTYPE_DOORB  = 4'hA;
  localparam logic [3:0] FTYPE_MESSG  = 4'hB;
  localparam logic [3:0] FTYPE_RESP   = 4'hD;

  localparam logic [15:0] DB_RDY_BASE = 16'h0100;
  localparam logic [15:0] DB_NRDY     = 16'h01FF;

  typedef struct packed {
    logic [7:0]  tid;
    logic [15:0] srcid;
    logic [15:0] info;
  } db_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } resp_state_e;

  // Channels outside the implemented range always report not-ready.
  function automatic logic [15:0] ready_info(input logic [4:0] ch, input logic [31:0] ready,
                                             input int unsigned n_ed);
    if ((32'(ch) < n_ed) && ready[ch])
      return DB_RDY_BASE | {11'b0, ch};
    return DB_NRDY;
  endfunction

endpackage

// File: rtl/db_resp_q_if.sv
// Request and response AXI-Stream channels between the SRIO logical layer and the doorbell responder.
interface db_resp_q_if;

  logic        treq_tvalid_in;
  logic        treq_tready_o;
  logic        treq_tlast_in;
  logic [63:0] treq_tdata_in;
  logic [7:0]  treq_tkeep_in;
  logic [31:0] treq_tuser_in;

  logic        tresp_tready_in;
  logic        tresp_tvalid_o;
  logic        tresp_tlast_o;
  logic [63:0] tresp_tdata_o;
  logic [7:0]  tresp_tkeep_o;
  logic [31:0] tresp_tuser_o;

  modport slave (
    input  treq_tvalid_in, treq_tlast_in, treq_tdata_in, treq_tkeep_in, treq_tuser_in,
    input  tresp_tready_in,
    output treq_tready_o,
    output tresp_tvalid_o, tresp_tlast_o, tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o
  );

  modport master (
    output treq_tvalid_in, treq_tlast_in, treq_tdata_in, treq_tkeep_in, treq_tuser_in,
    output tresp_tready_in,
    input  treq_tready_o,
    input  tresp_tvalid_o, tresp_tlast_o, tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o
  );

endinterface

// File: rtl/db_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the pointers wrap naturally.
module db_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/db_resp_q.sv
// Doorbell responder: queues incoming DOORB requests and answers each with a single-beat response.
// Optional DB_RESP_STATS_EN adds saturating rx_db_cnt / tx_resp_cnt / nack_cnt statistics outputs.
module db_resp_q
  import db_pkg::*;
#(
  parameter int          N_ED      = 4,
  parameter int          DEPTH     = 8,
  parameter logic [1:0]  RESP_PRIO = 2'h1
) (
  input  logic            log_clk,
  input  logic            log_rst,
  input  logic [15:0]     src_id,
  input  logic [N_ED-1:0] ed_ready_in,
  db_resp_q_if.slave      bus
`ifdef DB_RESP_STATS_EN
  ,
  output logic [15:0]     rx_db_cnt,
  output logic [15:0]     tx_resp_cnt,
  output logic [15:0]     nack_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  db_req_t     push_req;
  db_req_t     head_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        accept;
  logic        push;
  logic        pop;
  logic        first_beat;
  logic        load;
  logic        clear;
  logic [15:0] info_out;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [31:0] resp_user;
  logic        unused_bits;
  resp_state_e state;
  resp_state_e state_nx;

  assign bus.treq_tready_o = !fifo_full;
  assign accept = bus.treq_tvalid_in && bus.treq_tready_o;
  assign push   = accept && first_beat && (bus.treq_tdata_in[55:52] == FTYPE_DOORB);

  assign push_req = '{tid:   bus.treq_tdata_in[63:56],
                      srcid: bus.treq_tuser_in[31:16],
                      info:  bus.treq_tdata_in[31:16]};

  assign unused_bits = ^{bus.treq_tkeep_in, bus.treq_tdata_in[51:32], bus.treq_tdata_in[15:0],
                         bus.treq_tuser_in[15:0], fifo_count};

  // Only the first beat of a packet carries a header worth decoding.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst)     first_beat <= 1'b1;
    else if (accept) first_beat <= bus.treq_tlast_in;
  end

  db_sync_fifo #(
    .WIDTH ($bits(db_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (log_clk),
    .rst   (log_rst),
    .push  (push),
    .pop   (pop),
    .din   (push_req),
    .dout  (head_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tresp_tready_in) begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            clear    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Endpoint readiness is captured when the request leaves the FIFO, not when it arrived.
  assign info_out = ready_info(head_req.info[4:0], 32'(ed_ready_in), N_ED);

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_user  <= '0;
    end else if (load) begin
      resp_valid <= 1'b1;
      resp_data  <= {head_req.tid, FTYPE_DOORB, 4'h0, 1'b0, RESP_PRIO, 1'b0, 12'h0, info_out, 16'h0};
      resp_user  <= {src_id, head_req.srcid};
    end else if (clear) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_user  <= '0;
    end
  end

  assign bus.tresp_tvalid_o = resp_valid;
  assign bus.tresp_tlast_o  = resp_valid;
  assign bus.tresp_tkeep_o  = {8{resp_valid}};
  assign bus.tresp_tdata_o  = resp_data;
  assign bus.tresp_tuser_o  = resp_user;

`ifdef DB_RESP_STATS_EN
  logic tx_hs;
  assign tx_hs = resp_valid && bus.tresp_tready_in;

  // Statistics saturate instead of wrapping so a stuck counter reads as "very many".
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      rx_db_cnt   <= '0;
      tx_resp_cnt <= '0;
      nack_cnt    <= '0;
    end else begin
      if (push && (rx_db_cnt != 16'hFFFF))  rx_db_cnt   <= rx_db_cnt + 1'b1;
      if (tx_hs && (tx_resp_cnt != 16'hFFFF)) tx_resp_cnt <= tx_resp_cnt + 1'b1;
      if (tx_hs && (resp_data[31:16] == DB_NRDY) && (nack_cnt != 16'hFFFF))
        nack_cnt <= nack_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_db_resp_q.sv
// Randomised self-checking bench for db_resp_q against a queue-based model of the expected responses.
// Define DB_RESP_STATS_EN to also exercise the statistics counters.
module tb_db_resp_q;

  localparam int N_ED  = 4;
  localparam int DEPTH = 8;
  localparam logic [3:0] FT_DOORB  = 4'hA;
  localparam logic [3:0] FT_NWRITE = 4'h5;
  localparam logic [3:0] FT_SWRITE = 4'h6;
  localparam logic [3:0] FT_NREAD  = 4'h2;

  logic            log_clk = 1'b0;
  logic            log_rst;
  logic [15:0]     src_id;
  logic [N_ED-1:0] ed_ready;

  db_resp_q_if bus();

`ifdef DB_RESP_STATS_EN
  logic [15:0] rx_db_cnt;
  logic [15:0] tx_resp_cnt;
  logic [15:0] nack_cnt;
`endif

  db_resp_q #(
    .N_ED      (N_ED),
    .DEPTH     (DEPTH),
    .RESP_PRIO (2'h1)
  ) dut (
    .log_clk     (log_clk),
    .log_rst     (log_rst),
    .src_id      (src_id),
    .ed_ready_in (ed_ready),
    .bus         (bus)
`ifdef DB_RESP_STATS_EN
    ,
    .rx_db_cnt   (rx_db_cnt),
    .tx_resp_cnt (tx_resp_cnt),
    .nack_cnt    (nack_cnt)
`endif
  );

  always #5 log_clk = ~log_clk;

  typedef struct {
    logic [63:0] tdata;
    logic [31:0] tuser;
    logic        tlast;
    logic [7:0]  tkeep;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [63:0] tdata;
    logic [31:0] tuser;
  } exp_t;

  resp_t got_q[$];
  exp_t  exp_q[$];
  int    passed = 0;
  int    total  = 0;
  int    cyc    = 0;

  // Outputs are stable at the falling edge, so a handshake seen here completes at the next rising edge.
  always @(negedge log_clk) begin
    resp_t r;
    cyc = cyc + 1;
    if (!log_rst && bus.tresp_tvalid_o && bus.tresp_tready_in) begin
      r.tdata = bus.tresp_tdata_o;
      r.tuser = bus.tresp_tuser_o;
      r.tlast = bus.tresp_tlast_o;
      r.tkeep = bus.tresp_tkeep_o;
      r.cyc   = cyc;
      got_q.push_back(r);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not complete, got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] model_tdata(input logic [7:0] tid, input logic [15:0] info,
                                              input logic [N_ED-1:0] ed);
    int          ch;
    logic        rdy;
    logic [15:0] io;
    ch  = int'(info[4:0]);
    rdy = 1'b0;
    if (ch < N_ED) rdy = ed[ch];
    io = rdy ? 16'(16'h0100 + ch) : 16'h01FF;
    return {tid, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h0, io, 16'h0};
  endfunction

  task automatic tick();
    @(posedge log_clk);
    #1;
  endtask

  task automatic send_packet(input logic [3:0] ftype, input logic [7:0] tid, input logic [15:0] info,
                             input logic [15:0] srcid, input int beats);
    bit          ok;
    logic [63:0] d;
    for (int b = 0; b < beats; b++) begin
      if (b == 0) begin
        d = {tid, ftype, 4'h0, 16'h0, info, 16'h0};
      end else begin
        d = {$urandom, $urandom};
        d[55:52] = FT_DOORB;
      end
      bus.treq_tvalid_in = 1'b1;
      bus.treq_tdata_in  = d;
      bus.treq_tuser_in  = {srcid, 16'($urandom)};
      bus.treq_tlast_in  = (b == beats - 1);
      bus.treq_tkeep_in  = 8'hFF;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge log_clk);
        if (bus.treq_tready_o) ok = 1'b1;
      end
      @(posedge log_clk);
      #1;
      bus.treq_tvalid_in = 1'b0;
      if (!ok) begin
        total++;
        $display("[TB] FAIL send_timeout tid=%h: treq_tready_o got 0, want 1", tid);
        return;
      end
    end
    if (ftype == FT_DOORB) exp_q.push_back('{model_tdata(tid, info, ed_ready), {src_id, srcid}});
  endtask

  task automatic wait_responses();
    for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    log_rst = 1'b1;
    bus.treq_tvalid_in  = 1'b0;
    bus.treq_tlast_in   = 1'b0;
    bus.treq_tdata_in   = '0;
    bus.treq_tkeep_in   = '0;
    bus.treq_tuser_in   = '0;
    bus.tresp_tready_in = 1'b0;
    ed_ready = '0;
    repeat (3) tick();
    total++; if (bus.tresp_tvalid_o !== 1'b0) $display("[TB] FAIL reset_tvalid got %b want 0", bus.tresp_tvalid_o); else passed++;
    total++; if (bus.tresp_tdata_o !== 64'h0) $display("[TB] FAIL reset_tdata got %h want 0", bus.tresp_tdata_o); else passed++;
    total++; if (bus.tresp_tuser_o !== 32'h0) $display("[TB] FAIL reset_tuser got %h want 0", bus.tresp_tuser_o); else passed++;
    total++; if (bus.tresp_tlast_o !== 1'b0) $display("[TB] FAIL reset_tlast got %b want 0", bus.tresp_tlast_o); else passed++;
    total++; if (bus.tresp_tkeep_o !== 8'h0) $display("[TB] FAIL reset_tkeep got %h want 0", bus.tresp_tkeep_o); else passed++;
    log_rst = 1'b0;
    tick();
    total++; if (bus.treq_tready_o !== 1'b1) $display("[TB] FAIL reset_treq_tready got %b want 1", bus.treq_tready_o); else passed++;
  endtask

  task automatic test_basic();
    got_q.delete(); exp_q.delete();
    ed_ready = 4'b0100;
    bus.tresp_tready_in = 1'b1;
    send_packet(FT_DOORB, 8'h3C, 16'h0002, 16'h00AB, 1);
    wait_responses();
    total++; if (got_q.size() != 1) $display("[TB] FAIL basic_count got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0].tdata[63:56] !== 8'h3C) $display("[TB] FAIL basic_tid got %h want 3c", got_q[0].tdata[63:56]); else passed++;
      total++; if (got_q[0].tdata[31:16] !== 16'h0102) $display("[TB] FAIL basic_info got %h want 0102", got_q[0].tdata[31:16]); else passed++;
      total++; if (got_q[0].tuser !== {src_id, 16'h00AB}) $display("[TB] FAIL basic_tuser got %h want %h", got_q[0].tuser, {src_id, 16'h00AB}); else passed++;
      total++; if (got_q[0].tlast !== 1'b1) $display("[TB] FAIL basic_tlast got %b want 1", got_q[0].tlast); else passed++;
      total++; if (got_q[0].tkeep !== 8'hFF) $display("[TB] FAIL basic_tkeep got %h want ff", got_q[0].tkeep); else passed++;
      total++; if (got_q[0].tdata !== exp_q[0].tdata) $display("[TB] FAIL basic_tdata got %h want %h", got_q[0].tdata, exp_q[0].tdata); else passed++;
    end
  endtask

  task automatic test_nack();
    got_q.delete(); exp_q.delete();
    ed_ready = 4'b0000;
    send_packet(FT_DOORB, 8'h11, 16'h0001, 16'h0022, 1);
    wait_responses();
    ed_ready = 4'b1111;
    send_packet(FT_DOORB, 8'h12, 16'h001F, 16'h0023, 1);
    wait_responses();
    total++; if (got_q.size() != 2) $display("[TB] FAIL nack_count got %0d want 2", got_q.size()); else passed++;
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      total++;
      if (got_q[i].tdata[31:16] !== 16'h01FF) $display("[TB] FAIL nack_info[%0d] got %h want 01ff", i, got_q[i].tdata[31:16]);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit          done;
    int          kind;
    logic [7:0]  tid;
    logic [15:0] info;
    for (int batch = 0; batch < 3; batch++) begin
      got_q.delete(); exp_q.delete();
      ed_ready = N_ED'($urandom);
      done = 1'b0;
      fork
        begin
          for (int p = 0; p < 16; p++) begin
            kind = int'($urandom_range(0, 9));
            tid  = 8'($urandom);
            info = {11'($urandom), 5'($urandom_range(0, 7))};
            if (kind == 5) info[4:0] = 5'h1F;
            case (kind)
              6:       send_packet(FT_DOORB, tid, info, 16'($urandom), 2);
              7:       send_packet(FT_NWRITE, tid, info, 16'($urandom), int'($urandom_range(1, 3)));
              8:       send_packet(FT_SWRITE, tid, info, 16'($urandom), 2);
              9:       send_packet(FT_NREAD, tid, info, 16'($urandom), 1);
              default: send_packet(FT_DOORB, tid, info, 16'($urandom), 1);
            endcase
            repeat ($urandom_range(0, 2)) tick();
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            tick();
            bus.tresp_tready_in = ($urandom_range(0, 3) != 0);
          end
        end
      join
      bus.tresp_tready_in = 1'b1;
      wait_responses();
      total++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++; if (got_q[i].tdata !== exp_q[i].tdata) $display("[TB] FAIL rand_tdata[%0d] got %h want %h", i, got_q[i].tdata, exp_q[i].tdata); else passed++;
        total++; if (got_q[i].tuser !== exp_q[i].tuser) $display("[TB] FAIL rand_tuser[%0d] got %h want %h", i, got_q[i].tuser, exp_q[i].tuser); else passed++;
        total++; if (got_q[i].tlast !== 1'b1 || got_q[i].tkeep !== 8'hFF) $display("[TB] FAIL rand_last_keep[%0d] got %b/%h want 1/ff", i, got_q[i].tlast, got_q[i].tkeep); else passed++;
      end
    end
  endtask

  // With the response stalled, one request sits in the output stage, so DEPTH+1 doorbells fill the block.
  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    ed_ready = 4'b1111;
    bus.tresp_tready_in = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      send_packet(FT_DOORB, 8'(8'h40 + k), {14'h0, 2'(k)}, 16'(16'h0100 + k), 1);
      if (k == DEPTH - 1) begin
        total++; if (bus.treq_tready_o !== 1'b1) $display("[TB] FAIL full_early got %b want 1", bus.treq_tready_o); else passed++;
      end
    end
    total++; if (bus.treq_tready_o !== 1'b0) $display("[TB] FAIL full_tready got %b want 0", bus.treq_tready_o); else passed++;
    fork
      send_packet(FT_DOORB, 8'h49, 16'h0003, 16'h0199, 1);
      begin
        repeat (6) tick();
        total++; if (bus.treq_tready_o !== 1'b0) $display("[TB] FAIL full_stall got %b want 0", bus.treq_tready_o); else passed++;
        total++; if (bus.tresp_tdata_o[63:56] !== 8'h40) $display("[TB] FAIL full_hold_tid got %h want 40", bus.tresp_tdata_o[63:56]); else passed++;
        total++; if (got_q.size() != 0) $display("[TB] FAIL full_no_resp got %0d want 0", got_q.size()); else passed++;
        bus.tresp_tready_in = 1'b1;
      end
    join
    wait_responses();
    total++; if (got_q.size() != DEPTH + 2) $display("[TB] FAIL b2b_count got %0d want %0d", got_q.size(), DEPTH + 2); else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i].tdata !== exp_q[i].tdata) $display("[TB] FAIL b2b_tdata[%0d] got %h want %h", i, got_q[i].tdata, exp_q[i].tdata); else passed++;
      if (i > 0 && i < DEPTH + 1) begin
        total++; if (got_q[i].cyc != got_q[0].cyc + i) $display("[TB] FAIL b2b_gap[%0d] got cycle %0d want %0d", i, got_q[i].cyc, got_q[0].cyc + i); else passed++;
      end
    end
  endtask

  task automatic test_non_doorbell();
    got_q.delete(); exp_q.delete();
    ed_ready = 4'b1111;
    bus.tresp_tready_in = 1'b1;
    send_packet(FT_NWRITE, 8'h77, 16'h0001, 16'h0AAA, 2);
    send_packet(FT_SWRITE, 8'h78, 16'h0002, 16'h0AAB, 1);
    send_packet(FT_DOORB, 8'h79, 16'h0003, 16'h0AAC, 1);
    wait_responses();
    total++; if (got_q.size() != 1) $display("[TB] FAIL nondb_count got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0].tdata !== exp_q[0].tdata) $display("[TB] FAIL nondb_tdata got %h want %h", got_q[0].tdata, exp_q[0].tdata); else passed++;
    end
  endtask

  task automatic test_reset_mid_send();
    bit seen;
    got_q.delete(); exp_q.delete();
    ed_ready = 4'b1111;
    bus.tresp_tready_in = 1'b0;
    send_packet(FT_DOORB, 8'h55, 16'h0000, 16'h0555, 1);
    send_packet(FT_DOORB, 8'h56, 16'h0001, 16'h0556, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.tresp_tvalid_o === 1'b1) seen = 1'b1;
      else tick();
    end
    total++; if (!seen) $display("[TB] FAIL rst_pre_valid got 0 want 1"); else passed++;
    #2;
    log_rst = 1'b1;
    #1;
    total++; if (bus.tresp_tvalid_o !== 1'b0) $display("[TB] FAIL rst_mid_tvalid got %b want 0", bus.tresp_tvalid_o); else passed++;
    total++; if (bus.tresp_tdata_o !== 64'h0) $display("[TB] FAIL rst_mid_tdata got %h want 0", bus.tresp_tdata_o); else passed++;
    total++; if (bus.tresp_tuser_o !== 32'h0 || bus.tresp_tlast_o !== 1'b0 || bus.tresp_tkeep_o !== 8'h0)
      $display("[TB] FAIL rst_mid_side got %h/%b/%h want 0/0/0", bus.tresp_tuser_o, bus.tresp_tlast_o, bus.tresp_tkeep_o);
    else passed++;
    tick();
    log_rst = 1'b0;
    got_q.delete(); exp_q.delete();
    bus.tresp_tready_in = 1'b1;
    repeat (10) tick();
    total++; if (got_q.size() != 0) $display("[TB] FAIL rst_after_resp got %0d want 0", got_q.size()); else passed++;
    total++; if (bus.treq_tready_o !== 1'b1) $display("[TB] FAIL rst_after_tready got %b want 1", bus.treq_tready_o); else passed++;
  endtask

`ifdef DB_RESP_STATS_EN
  task automatic test_stats();
    int n_nack;
    log_rst = 1'b1;
    tick();
    log_rst = 1'b0;
    tick();
    total++; if (rx_db_cnt !== 16'h0 || tx_resp_cnt !== 16'h0 || nack_cnt !== 16'h0)
      $display("[TB] FAIL stats_reset got %h/%h/%h want 0/0/0", rx_db_cnt, tx_resp_cnt, nack_cnt);
    else passed++;
    got_q.delete(); exp_q.delete();
    ed_ready = 4'b0011;
    bus.tresp_tready_in = 1'b1;
    send_packet(FT_DOORB, 8'h01, 16'h0000, 16'h0001, 1);
    send_packet(FT_NWRITE, 8'h02, 16'h0000, 16'h0001, 1);
    send_packet(FT_DOORB, 8'h03, 16'h0001, 16'h0001, 1);
    send_packet(FT_DOORB, 8'h04, 16'h0002, 16'h0001, 1);
    wait_responses();
    n_nack = 0;
    foreach (exp_q[i]) if (exp_q[i].tdata[31:16] == 16'h01FF) n_nack++;
    total++; if (rx_db_cnt !== 16'(exp_q.size())) $display("[TB] FAIL stats_rx got %0d want %0d", rx_db_cnt, exp_q.size()); else passed++;
    total++; if (tx_resp_cnt !== 16'(exp_q.size())) $display("[TB] FAIL stats_tx got %0d want %0d", tx_resp_cnt, exp_q.size()); else passed++;
    total++; if (nack_cnt !== 16'(n_nack)) $display("[TB] FAIL stats_nack got %0d want %0d", nack_cnt, n_nack); else passed++;
  endtask
`endif

  initial begin
    src_id = 16'($urandom);
    $display("[TB] starting db_resp_q bench, src_id=%h", src_id);
    test_reset();
    test_basic();
    test_nack();
    test_random();
    test_back_to_back();
    test_non_doorbell();
    test_reset_mid_send();
`ifdef DB_RESP_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
